// File: rtl/fetch_stage_if.sv
// Fetch-stage port bundle: hazard/redirect inputs, instruction-memory handshake, IF/ID outputs.
// master = environment (hazard unit, memory, decode), slave = fetch_stage.
interface fetch_stage_if;
  logic        StallD;
  logic        FlushD;
  logic        BranchTakenE;
  logic [31:0] ALUResultE;
  logic        PCSrcW;
  logic [31:0] ResultW;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] InstD;
  logic [31:0] PCPlus8D;
  logic        ValidD;
  logic [31:0] PCF;

  modport master (
    output StallD, FlushD, BranchTakenE, ALUResultE, PCSrcW, ResultW, imem_ack, imem_rdata,
    input  imem_req, imem_addr, InstD, PCPlus8D, ValidD, PCF
  );

  modport slave (
    input  StallD, FlushD, BranchTakenE, ALUResultE, PCSrcW, ResultW, imem_ack, imem_rdata,
    output imem_req, imem_addr, InstD, PCPlus8D, ValidD, PCF
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, runs a req/ack memory handshake and loads IF/ID (one edge after ack).
// Decode stall parks a returned word in HOLD; redirects during a wait let the stale fetch drain first.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.slave bus
);
  typedef enum logic [1:0] {REQ, HOLD, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc8;
    logic        vld;
  } ifid_t;

  state_t      r_state;
  logic [31:0] r_req_addr;
  logic [31:0] r_pending_pc;
  logic [31:0] r_hold_inst;
  ifid_t       r_ifid;

  logic        w_redirect;
  logic [31:0] w_target;

  assign w_redirect = bus.BranchTakenE | bus.PCSrcW;
  assign w_target   = bus.BranchTakenE ? bus.ALUResultE : bus.ResultW;

  // Gated by reset so the request drops the instant reset asserts, mid-handshake included.
  assign bus.imem_req  = reset & (r_state != HOLD);
  assign bus.imem_addr = r_req_addr;
  assign bus.PCF       = r_req_addr;
  assign bus.InstD     = r_ifid.inst;
  assign bus.PCPlus8D  = r_ifid.pc8;
  assign bus.ValidD    = r_ifid.vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= REQ;
      r_req_addr   <= RESET_PC;
      r_pending_pc <= '0;
      r_hold_inst  <= '0;
      r_ifid       <= '0;
    end else begin
      case (r_state)
        REQ: begin
          if (w_redirect) begin
            if (bus.imem_ack) begin
              r_req_addr <= w_target;
            end else begin
              r_pending_pc <= w_target;
              r_state      <= DRAIN;
            end
            if (!bus.StallD) r_ifid <= '0;
          end else if (bus.imem_ack) begin
            if (!bus.StallD) begin
              r_ifid     <= '{inst: bus.imem_rdata, pc8: r_req_addr + 32'd8, vld: 1'b1};
              r_req_addr <= r_req_addr + 32'd4;
            end else begin
              r_hold_inst <= bus.imem_rdata;
              r_state     <= HOLD;
            end
          end else if (!bus.StallD) begin
            r_ifid <= '0;
          end
        end
        HOLD: begin
          if (w_redirect) begin
            r_req_addr <= w_target;
            r_state    <= REQ;
            if (!bus.StallD) r_ifid <= '0;
          end else if (!bus.StallD) begin
            r_ifid     <= '{inst: r_hold_inst, pc8: r_req_addr + 32'd8, vld: 1'b1};
            r_req_addr <= r_req_addr + 32'd4;
            r_state    <= REQ;
          end
        end
        DRAIN: begin
          // The outstanding word belongs to the old path; it is discarded on arrival.
          if (w_redirect) r_pending_pc <= w_target;
          if (bus.imem_ack) begin
            r_req_addr <= w_redirect ? w_target : r_pending_pc;
            r_state    <= REQ;
          end
          if (!bus.StallD) r_ifid <= '0;
        end
        default: r_state <= REQ;
      endcase
      if (bus.FlushD) r_ifid <= '0;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a transaction-level model predicts every cycle's request and IF/ID contents.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if if1 ();
  fetch_stage_if if2 ();

  logic [31:0] key = 32'h0;
  assign if1.imem_rdata = if1.imem_addr ^ key;
  assign if2.imem_rdata = if2.imem_addr;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .reset(reset), .bus(if1.slave));
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (.clk(clk), .reset(reset), .bus(if2.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: address of the fetch in progress, a parked word awaiting Decode,
  // and a pending redirect target that takes effect once the stale fetch returns.
  logic [31:0] m_addr, m_buf, m_tgt, m_inst, m_pc8;
  bit          m_buffered, m_stale, m_vld;
  bit          mem_busy;
  int          wait_left;

  task automatic model_reset();
    m_addr = 32'h0; m_buf = 32'h0; m_tgt = 32'h0;
    m_inst = 32'h0; m_pc8 = 32'h0; m_vld = 1'b0;
    m_buffered = 1'b0; m_stale = 1'b0;
    mem_busy = 1'b0; wait_left = 0;
  endtask

  task automatic model_step(input bit stall, input bit flush, input bit bt, input bit pcs,
                            input bit ack, input logic [31:0] alu, input logic [31:0] res,
                            input logic [31:0] rd);
    bit          redir;
    logic [31:0] t, ni, np;
    bit          nv;
    redir = bt | pcs;
    t  = bt ? alu : res;
    ni = stall ? m_inst : 32'h0;
    np = stall ? m_pc8  : 32'h0;
    nv = stall ? m_vld  : 1'b0;
    if (m_buffered) begin
      if (redir) begin
        m_buffered = 1'b0;
        m_addr = t;
      end else if (!stall) begin
        ni = m_buf; np = m_addr + 32'd8; nv = 1'b1;
        m_addr = m_addr + 32'd4;
        m_buffered = 1'b0;
      end
    end else begin
      if (redir) begin
        m_stale = 1'b1;
        m_tgt = t;
      end
      if (ack) begin
        if (m_stale) begin
          m_addr = m_tgt;
          m_stale = 1'b0;
        end else if (!stall) begin
          ni = rd; np = m_addr + 32'd8; nv = 1'b1;
          m_addr = m_addr + 32'd4;
        end else begin
          m_buffered = 1'b1;
          m_buf = rd;
        end
      end
    end
    if (flush) begin
      ni = 32'h0; np = 32'h0; nv = 1'b0;
    end
    m_inst = ni; m_pc8 = np; m_vld = nv;
  endtask

  // One cycle at the falling edge: compare, pick stimulus, step the model, advance.
  task automatic do_cycle(input int wmin, input int wmax, input int stall_pct,
                          input int flush_pct, input int red_pct);
    bit          s_stall, s_flush, s_bt, s_pcs, s_ack;
    logic [31:0] s_alu, s_res;
    check32("imem_req",  32'(if1.imem_req), 32'(!m_buffered));
    check32("imem_addr", if1.imem_addr, m_addr);
    check32("PCF",       if1.PCF, m_addr);
    check32("InstD",     if1.InstD, m_inst);
    check32("PCPlus8D",  if1.PCPlus8D, m_pc8);
    check32("ValidD",    32'(if1.ValidD), 32'(m_vld));
    s_stall = ($urandom_range(99, 0) < stall_pct);
    s_flush = ($urandom_range(99, 0) < flush_pct);
    s_bt    = ($urandom_range(99, 0) < red_pct);
    s_pcs   = ($urandom_range(99, 0) < red_pct);
    s_alu   = $urandom & 32'hFFFF_FFFC;
    s_res   = $urandom & 32'hFFFF_FFFC;
    s_ack   = 1'b0;
    if (!m_buffered) begin
      if (!mem_busy) begin
        mem_busy  = 1'b1;
        wait_left = $urandom_range(wmax, wmin);
      end
      if (wait_left == 0) begin
        s_ack = 1'b1;
        mem_busy = 1'b0;
      end else begin
        wait_left--;
      end
    end
    if1.StallD = s_stall; if1.FlushD = s_flush;
    if1.BranchTakenE = s_bt; if1.ALUResultE = s_alu;
    if1.PCSrcW = s_pcs; if1.ResultW = s_res;
    if1.imem_ack = s_ack;
    model_step(s_stall, s_flush, s_bt, s_pcs, s_ack, s_alu, s_res, m_addr ^ key);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    if1.StallD = 1'b0; if1.FlushD = 1'b0; if1.BranchTakenE = 1'b0;
    if1.ALUResultE = 32'h0; if1.PCSrcW = 1'b0; if1.ResultW = 32'h0; if1.imem_ack = 1'b0;
  endtask

  initial begin
    drive_idle();
    if2.StallD = 1'b0; if2.FlushD = 1'b0; if2.BranchTakenE = 1'b0;
    if2.ALUResultE = 32'h0; if2.PCSrcW = 1'b0; if2.ResultW = 32'h0; if2.imem_ack = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check32("rst_req",   32'(if1.imem_req), 32'h0);
    check32("rst_PCF",   if1.PCF, 32'h0);
    check32("rst_valid", 32'(if1.ValidD), 32'h0);
    check32("rst_PCF_w", if2.PCF, 32'hFFFF_FFFC);
    @(negedge clk);
    reset = 1'b1;
    #1;

    // Zero-wait memory returning the address: 0,4,8,12 stream into IF/ID; wrap instance alongside.
    for (int k = 0; k < 6; k++) begin
      if (k >= 1 && k <= 4) begin
        check32("zw_inst", if1.InstD, 32'(4 * (k - 1)));
        check32("zw_pc8",  if1.PCPlus8D, 32'(4 * (k - 1) + 8));
        check32("zw_vld",  32'(if1.ValidD), 32'h1);
      end
      if (k == 0) check32("wrap_pcf0", if2.PCF, 32'hFFFF_FFFC);
      if (k == 1) begin
        check32("wrap_inst0", if2.InstD, 32'hFFFF_FFFC);
        check32("wrap_pc8_0", if2.PCPlus8D, 32'h0000_0004);
        check32("wrap_pcf1",  if2.PCF, 32'h0);
      end
      if (k == 2) begin
        check32("wrap_inst1", if2.InstD, 32'h0);
        check32("wrap_pc8_1", if2.PCPlus8D, 32'h0000_0008);
      end
      do_cycle(0, 0, 0, 0, 0);
    end

    // Two wait cycles per fetch, then decode stalls, then redirects on top of waits.
    for (int k = 0; k < 12; k++) do_cycle(2, 2, 0, 0, 0);
    for (int k = 0; k < 40; k++) do_cycle(0, 2, 40, 0, 0);
    for (int k = 0; k < 40; k++) do_cycle(1, 3, 0, 0, 15);

    key = 32'h5A5A_C3C3;
    for (int k = 0; k < 1500; k++) do_cycle(0, 3, 25, 10, 8);

    // Asynchronous reset in the middle of a cycle.
    #2;
    reset = 1'b0;
    #1;
    check32("mid_rst_req",   32'(if1.imem_req), 32'h0);
    check32("mid_rst_PCF",   if1.PCF, 32'h0);
    check32("mid_rst_inst",  if1.InstD, 32'h0);
    check32("mid_rst_valid", 32'(if1.ValidD), 32'h0);
    drive_idle();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 1500; k++) do_cycle(0, 4, 30, 5, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined processor. It owns the program counter, issues instruction-memory requests over a request/acknowledge handshake with variable wait states, and loads the IF/ID pipeline register that feeds Decode (InstD, PCPlus8D). It inserts bubbles while memory is busy, buffers a returned instruction when Decode stalls, and squashes in-flight fetches on branch or PC-write redirects.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- StallD  in  1  hold the IF/ID register and stop PC advance (hazard unit).
- FlushD  in  1  clear the IF/ID register to a bubble at the next edge.
- BranchTakenE  in  1  branch resolved taken in Execute.
- ALUResultE  in  32  branch target from Execute.
- PCSrcW  in  1  instruction in Writeback writes the PC.
- ResultW  in  32  PC value from Writeback.
- imem_req  out  1  request valid.
- imem_addr  out  32  request address (word-aligned).
- imem_ack  in  1  one-cycle acknowledge; imem_rdata valid in that cycle only.
- imem_rdata  in  32  instruction word.
- InstD  out  32  IF/ID instruction.
- PCPlus8D  out  32  IF/ID fetch address + 8.
- ValidD  out  1  IF/ID holds a real instruction (0 = bubble).
- PCF  out  32  current request address (equals imem_addr).

## Operation
- Registers: state {REQ, HOLD, DRAIN}, req_addr, pending_pc, hold_inst, IF/ID (InstD, PCPlus8D, ValidD).
- imem_req = 1 in REQ and DRAIN, 0 in HOLD and while reset is low; imem_addr = req_addr. Once raised, req and addr stay stable until ack (no abandonment).
- Redirect = BranchTakenE | PCSrcW; target T = BranchTakenE ? ALUResultE : ResultW (branch wins). Redirect overrides StallD for fetch state.
- REQ, redirect: ack -> drop rdata, req_addr<=T, stay REQ; no ack -> pending_pc<=T, go DRAIN.
- REQ, no redirect, ack: !StallD -> IF/ID<={rdata, req_addr+8, 1}, req_addr<=req_addr+4; StallD -> hold_inst<=rdata, go HOLD.
- REQ, no redirect, no ack: !StallD -> IF/ID<=bubble; StallD -> IF/ID holds.
- HOLD: redirect -> drop hold_inst, req_addr<=T, go REQ; else !StallD -> IF/ID<={hold_inst, req_addr+8, 1}, req_addr+=4, go REQ; else stay.
- DRAIN: redirect -> pending_pc<=T (newest wins); ack -> drop rdata, req_addr<=pending_pc (or T if redirect same cycle), go REQ; IF/ID gets bubble when !StallD.
- FlushD: IF/ID<=bubble regardless of StallD or any load above; fetch state updates unaffected.
- Bubble = InstD 0, PCPlus8D 0, ValidD 0.
- Address arithmetic modulo 2^32: 32'hFFFF_FFFC+4 -> 0; PCPlus8D of 32'hFFFF_FFFC = 32'h0000_0004.

## Timing
- Reset (low): state REQ, req_addr=RESET_PC, pending_pc=0, hold_inst=0, IF/ID bubble, imem_req=0; PCF=RESET_PC. First request in first cycle after release.
- Zero-wait memory (ack in request cycle): one instruction per cycle, IF/ID valid one edge after ack.
- N wait cycles: N bubbles into IF/ID, then instruction.
- Redirect with no outstanding wait: first request to T in next cycle; redirect during wait adds remaining wait cycles of stale fetch.
- Reset mid-request: imem_req drops asynchronously; memory must discard the request.

## Test plan
- Reset release, zero-wait memory returning addr as data: InstD 0,4,8,12 on consecutive edges, PCPlus8D 8,12,16,20, ValidD=1.
- Two wait cycles per fetch: IF/ID pattern bubble, bubble, inst@0, bubble, bubble, inst@4; imem_addr stable through waits.
- StallD for 3 cycles coincident with ack at 0x10: imem_req low 3 cycles, IF/ID holds prior, then inst@0x10 loads, next request 0x14.
- BranchTakenE with ALUResultE=0x100 during second wait cycle of fetch at 0x20: stale 0x20 data dropped, next request 0x100, no valid 0x20 in IF/ID.
- BranchTakenE=0x200 and PCSrcW=0x300 together, FlushD=1: next fetch 0x200, IF/ID bubble next edge.
- Wrap: RESET_PC=32'hFFFF_FFFC -> fetches FFFF_FFFC then 0, PCPlus8D 4 then 8.
